// File: rtl/e203_exu_dsp_simd_adder.sv
// Two-stage SIMD add/subtract unit with 8/16/32-bit lanes, per-lane overflow
// detection and an optional saturating result stage.
// Optional feature macro: E203_DSP_SAT_EN builds the saturation logic; without
// it i_sat is ignored and lane results always wrap.
module e203_exu_dsp_simd_adder #(
  parameter int DW     = 32,
  parameter int ITAG_W = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_valid,
  output logic              i_ready,
  input  logic [DW-1:0]     i_op1,
  input  logic [DW-1:0]     i_op2,
  input  logic              i_sub,
  input  logic [1:0]        i_mode,
  input  logic              i_sgn,
  input  logic              i_sat,
  input  logic [ITAG_W-1:0] i_itag,
  output logic              o_valid,
  input  logic              o_ready,
  output logic [DW-1:0]     o_res,
  output logic [ITAG_W-1:0] o_itag,
  output logic              o_ov,
  output logic              ov_sticky,
  input  logic              ov_clr,
  input  logic              flush
);

  localparam int NB = DW / 8;

  // ---------------- handshake ----------------
  logic s1_vld_q, s1_vld_d;
  logic s2_vld_q, s2_vld_d;
  logic s2_adv, acc, s1_mv;

  assign s2_adv  = ~s2_vld_q | o_ready;
  assign i_ready = ~s1_vld_q | s2_adv;
  assign acc     = i_valid & i_ready;
  assign s1_mv   = s1_vld_q & s2_adv;

  // ---------------- stage 1: byte-sliced adder ----------------
  // Every lane is built from byte slices; the carry chain is cut at each
  // lane start, where the carry-in is i_sub (two's complement subtract).
  logic m8, m16, m32;
  assign m8  = (i_mode == 2'b00);
  assign m16 = (i_mode == 2'b01);
  assign m32 = i_mode[1];

  logic [NB-1:0][7:0] a, bx, s;
  logic [NB-1:0]      cin, cy, top, ov;

  assign a  = i_op1;
  assign bx = i_sub ? ~i_op2 : i_op2;

  for (genvar b = 0; b < NB; b++) begin : g_s1
    localparam logic ODD = ((b % 2) == 1);
    localparam logic Q0  = ((b % 4) == 0);
    localparam logic Q3  = ((b % 4) == 3);
    if (b == 0) begin : g_lsb
      assign cin[b] = i_sub;
    end else begin : g_mid
      assign cin[b] = (m8 | (m16 & ~ODD) | (m32 & Q0)) ? i_sub : cy[b-1];
    end
    assign top[b] = m8 | (m16 & ODD) | (m32 & Q3);
    assign {cy[b], s[b]} = {1'b0, a[b]} + {1'b0, bx[b]} + {8'd0, cin[b]};
    // Only the lane's top byte carries a meaningful overflow bit.
    assign ov[b] = top[b] & (i_sgn ? ((a[b][7] == bx[b][7]) & (s[b][7] != a[b][7]))
                                   : (cy[b] ^ i_sub));
  end

  logic [NB-1:0][7:0] s1_sum_q, s1_op2x_q;
  logic [NB-1:0]      s1_ov_q;
  logic [ITAG_W-1:0]  s1_itag_q;

  // Stage-1 valid: flush wins, then a new accept, then drain into stage 2.
  always_comb begin
    s1_vld_d = s1_vld_q;
    if (flush)      s1_vld_d = 1'b0;
    else if (acc)   s1_vld_d = 1'b1;
    else if (s1_mv) s1_vld_d = 1'b0;
  end

  // Stage-1 valid register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) s1_vld_q <= 1'b0;
    else        s1_vld_q <= s1_vld_d;
  end

  // Stage-1 data loads on every accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_sum_q  <= '0;
      s1_op2x_q <= '0;
      s1_ov_q   <= '0;
      s1_itag_q <= '0;
    end else if (acc) begin
      s1_sum_q  <= s;
      s1_op2x_q <= bx;
      s1_ov_q   <= ov;
      s1_itag_q <= i_itag;
    end
  end

  // ---------------- stage 2: wrap / saturate ----------------
  logic [NB-1:0][7:0] res_d;

`ifdef E203_DSP_SAT_EN
  logic [1:0] s1_mode_q;
  logic       s1_sgn_q, s1_sub_q, s1_sat_q;
  logic       q8, q16;

  // Lane configuration is only needed again when saturating.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_mode_q <= 2'b00;
      s1_sgn_q  <= 1'b0;
      s1_sub_q  <= 1'b0;
      s1_sat_q  <= 1'b0;
    end else if (acc) begin
      s1_mode_q <= i_mode;
      s1_sgn_q  <= i_sgn;
      s1_sub_q  <= i_sub;
      s1_sat_q  <= i_sat;
    end
  end

  assign q8  = (s1_mode_q == 2'b00);
  assign q16 = (s1_mode_q == 2'b01);

  for (genvar b = 0; b < NB; b++) begin : g_s2
    localparam int   T16 = b | 1;
    localparam int   T32 = b | 3;
    localparam logic ODD = ((b % 2) == 1);
    localparam logic Q3  = ((b % 4) == 3);
    logic       lane_ov, neg, is_top;
    logic [7:0] satv;
    assign lane_ov = q8 ? s1_ov_q[b] : (q16 ? s1_ov_q[T16] : s1_ov_q[T32]);
    // A signed overflow implies op1 and (inverted) op2 share a sign, so the
    // registered op2 sign tells whether op1 was negative.
    assign neg     = q8 ? s1_op2x_q[b][7] : (q16 ? s1_op2x_q[T16][7] : s1_op2x_q[T32][7]);
    assign is_top  = q8 | (q16 & ODD) | (~q8 & ~q16 & Q3);
    assign satv    = s1_sgn_q ? (is_top ? {neg, {7{~neg}}} : {8{~neg}})
                              : {8{~s1_sub_q}};
    assign res_d[b] = (s1_sat_q & lane_ov) ? satv : s1_sum_q[b];
  end

  logic unused_sat;
  assign unused_sat = 1'b0;
`else
  assign res_d = s1_sum_q;

  logic unused_nosat;
  assign unused_nosat = ^{i_sat, s1_op2x_q};
`endif

  logic [DW-1:0]     res_q;
  logic [ITAG_W-1:0] itag_q;
  logic              ovf_q;

  // Stage-2 valid: flush wins, otherwise take stage 1 whenever allowed to move.
  always_comb begin
    s2_vld_d = s2_vld_q;
    if (flush)       s2_vld_d = 1'b0;
    else if (s2_adv) s2_vld_d = s1_vld_q;
  end

  // Stage-2 valid register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) s2_vld_q <= 1'b0;
    else        s2_vld_q <= s2_vld_d;
  end

  // Result registers only change when a real op moves in, so they hold under stall.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_q  <= '0;
      itag_q <= '0;
      ovf_q  <= 1'b0;
    end else if (s1_mv) begin
      res_q  <= res_d;
      itag_q <= s1_itag_q;
      ovf_q  <= |s1_ov_q;
    end
  end

  assign o_valid = s2_vld_q;
  assign o_res   = res_q;
  assign o_itag  = itag_q;
  assign o_ov    = ovf_q;

  // ---------------- sticky overflow ----------------
  // A result presented in a flush cycle counts as flushed and does not set it.
  logic sticky_q, sticky_d;
  always_comb begin
    sticky_d = (s2_vld_q & o_ready & ovf_q & ~flush) | (sticky_q & ~ov_clr);
  end

  // Sticky overflow register; set has priority over clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sticky_q <= 1'b0;
    else        sticky_q <= sticky_d;
  end

  assign ov_sticky = sticky_q;

endmodule
